// File: rtl/button_event_module.sv
// ============================================================================
// Module      : button_event_module
// Description : Turns a debounced, clk-synchronous button level into one-cycle
//               press / release / long-press / auto-repeat strobes, a "held"
//               level and an 8-bit wrapping press counter.
//               Optional feature macro: AUTO_REPEAT_EN
//                 defined   -> repeat_pulse every REPEAT_CYCLES in long hold
//                 undefined -> repeat_pulse tied low, cnt parked at 0 in
//                              LONG_HELD
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_module #(
    parameter int unsigned LONG_CYCLES   = 10_000_000,  // press -> long_pulse, 2..2^24-1
    parameter int unsigned REPEAT_CYCLES = 2_500_000    // auto-repeat period, 2..2^24-1
) (
    input  logic       clk,
    input  logic       reset,          // asynchronous, active-low
    input  logic       button_clean,   // 1 = pressed
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    // Terminal counts: the threshold edge is the one where cnt already holds
    // N-1, so the strobe lands exactly N cycles after the previous event.
    localparam logic [23:0] LONG_LAST   = 24'(LONG_CYCLES - 1);
    localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic        btn_q;

    logic press_evt;
    logic release_evt;

    // Edge detection against the previous-cycle button level.
    assign press_evt   =  button_clean & ~btn_q;
    assign release_evt = ~button_clean &  btn_q;

    // Button state machine with registered strobes, held level and counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_q         <= 1'b0;
            press_count   <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            btn_q         <= button_clean;
            // Strobes default low so each lasts exactly one cycle.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    held <= 1'b0;
                    if (press_evt) begin
                        press_pulse <= 1'b1;
                        state       <= PRESSED;
                        cnt         <= '0;
                        held        <= 1'b1;
                        press_count <= press_count + 8'd1;  // wraps 255 -> 0
                    end
                end

                PRESSED: begin
                    // A release wins over a threshold reached on the same edge.
                    if (release_evt) begin
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                        cnt           <= '0;
                        held          <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        long_pulse <= 1'b1;
                        state      <= LONG_HELD;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end

                LONG_HELD: begin
                    if (release_evt) begin
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                        cnt           <= '0;
                        held          <= 1'b0;
                    end else if (AUTO_REPEAT && (cnt == REPEAT_LAST)) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                    end else if (AUTO_REPEAT) begin
                        cnt <= cnt + 24'd1;
                    end else begin
                        // Without auto-repeat the counter is parked.
                        cnt <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_event_module.sv
// ============================================================================
// Module      : tb_button_event_module
// Description : Directed self-checking bench for button_event_module with
//               LONG_CYCLES=8, REPEAT_CYCLES=4. Expectations follow the
//               AUTO_REPEAT_EN macro setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_event_module;

    localparam int LONG = 8;
    localparam int REP  = 4;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       button_clean;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_pc;

    logic [4:0] obs;
    assign obs = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};

    button_event_module #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_clean  (button_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held low while the button toggles: everything stays zero.
    task automatic test_reset();
        reset        = 1'b0;
        button_clean = 1'b0;
        #2;
        for (int j = 0; j < 6; j++) begin
            button_clean = j[0];
            tick();
            checks++;
            if (obs !== 5'b0 || press_count !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: outputs(p,r,l,rp,h)=%b count=%0d, expected 00000 count 0",
                         j, obs, press_count);
            end
        end
        button_clean = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 5'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_release_idle: outputs=%b count=%0d, expected 00000 count 0", obs, press_count);
        end
        exp_pc = 8'd0;
    endtask

    // Three-cycle press: press at k, release at k+3, held k..k+2, no long.
    task automatic test_short_press();
        logic [4:0] exp;
        button_clean = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (j == 3) button_clean = 1'b0;
            tick();
            exp = {(j == 0), (j == 3), 1'b0, 1'b0, (j < 3)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL short_press edge k+%0d: outputs=%b, expected %b", j, obs, exp);
            end
        end
        exp_pc = exp_pc + 8'd1;
        checks++;
        if (press_count !== exp_pc) begin
            errors++;
            $display("FAIL short_press_count: count=%0d, expected %0d", press_count, exp_pc);
        end
    endtask

    // 22-cycle hold: long at k+8, repeats at k+12/16/20 if enabled, release k+22.
    task automatic test_long_hold();
        logic [4:0] exp;
        logic       rep;
        button_clean = 1'b1;
        for (int j = 0; j < 26; j++) begin
            if (j == 22) button_clean = 1'b0;
            tick();
            rep = AUTO && (j == 12 || j == 16 || j == 20);
            exp = {(j == 0), (j == 22), (j == 8), rep, (j < 22)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_hold edge k+%0d: outputs=%b, expected %b", j, obs, exp);
            end
        end
        exp_pc = exp_pc + 8'd1;
        checks++;
        if (press_count !== exp_pc) begin
            errors++;
            $display("FAIL long_hold_count: count=%0d, expected %0d", press_count, exp_pc);
        end
    endtask

    // Release landing on the long and repeat thresholds suppresses the strobe.
    task automatic test_release_at_threshold();
        logic [4:0] exp;
        button_clean = 1'b1;
        for (int j = 0; j < 11; j++) begin
            if (j == 8) button_clean = 1'b0;
            tick();
            exp = {(j == 0), (j == 8), 1'b0, 1'b0, (j < 8)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release_at_long edge k+%0d: outputs=%b, expected %b", j, obs, exp);
            end
        end
        button_clean = 1'b1;
        for (int j = 0; j < 15; j++) begin
            if (j == 12) button_clean = 1'b0;
            tick();
            exp = {(j == 0), (j == 12), (j == 8), 1'b0, (j < 12)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL release_at_repeat edge k+%0d: outputs=%b, expected %b", j, obs, exp);
            end
        end
        exp_pc = exp_pc + 8'd2;
        checks++;
        if (press_count !== exp_pc) begin
            errors++;
            $display("FAIL threshold_count: count=%0d, expected %0d", press_count, exp_pc);
        end
    endtask

    // 256 one-cycle presses after reset: counter reaches 255 then wraps to 0.
    task automatic test_count_wrap();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_start: count=%0d, expected 0", press_count);
        end
        for (int i = 0; i < 256; i++) begin
            button_clean = 1'b1;
            tick();
            button_clean = 1'b0;
            tick();
            if (i == 254) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: count=%0d, expected 255", press_count);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_0: count=%0d, expected 0", press_count);
        end
        exp_pc = 8'd0;
    endtask

    // Reset during LONG_HELD clears at once, no release; button high at
    // deassertion gives a press on the first edge.
    task automatic test_reset_mid_hold();
        button_clean = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (j == 8) begin
                checks++;
                if (long_pulse !== 1'b1 || held !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_hold_long: long=%b held=%b, expected 1 1", long_pulse, held);
                end
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b0 || press_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b count=%0d, expected 00000 count 0", obs, press_count);
        end
        for (int j = 0; j < 2; j++) begin
            tick();
            checks++;
            if (obs !== 5'b0 || press_count !== 8'd0) begin
                errors++;
                $display("FAIL reset_low_edge %0d: outputs=%b count=%0d, expected 00000 count 0",
                         j, obs, press_count);
            end
        end
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== 5'b10001 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL press_after_reset: outputs=%b count=%0d, expected 10001 count 1", obs, press_count);
        end
        button_clean = 1'b0;
        tick();
        checks++;
        if (obs !== 5'b01000) begin
            errors++;
            $display("FAIL release_after_reset: outputs=%b, expected 01000", obs);
        end
        tick();
        checks++;
        if (obs !== 5'b00000 || press_count !== 8'd1) begin
            errors++;
            $display("FAIL idle_after_reset: outputs=%b count=%0d, expected 00000 count 1", obs, press_count);
        end
    endtask

    initial begin
        exp_pc = 8'd0;
        test_reset();
        test_short_press();
        test_long_hold();
        tick();
        test_release_at_threshold();
        tick();
        test_count_wrap();
        tick();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_event_module.md
BUTTON_EVENT_MODULE -- requirements
Module: button_event_module

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 10_000_000, giving the hold duration in clk cycles from press_pulse to long_pulse; legal range 2..2^24-1.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 2_500_000, giving the auto-repeat period in clk cycles; legal range 2..2^24-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port button_clean, input, 1 bit: debounced, clk-synchronous button level; 1 = pressed.
REQ-006 Port press_pulse, output, 1 bit: one-cycle strobe on each press.
REQ-007 Port release_pulse, output, 1 bit: one-cycle strobe on each release.
REQ-008 Port long_pulse, output, 1 bit: one-cycle strobe when a press reaches LONG_CYCLES.
REQ-009 Port repeat_pulse, output, 1 bit: one-cycle strobe every REPEAT_CYCLES while in long hold.
REQ-010 Port held, output, 1 bit: level, 1 while state is not IDLE.
REQ-011 Port press_count, output, 8 bits: count of presses since reset.

Function
REQ-012 The block SHALL register button_clean into btn_q every edge; an edge k with button_clean=1 and btn_q=0 is a press event, and with button_clean=0 and btn_q=1 a release event.
REQ-013 The block SHALL register all outputs; each strobe SHALL be high for exactly one cycle, starting at the edge on which its event is detected.
REQ-014 States SHALL be IDLE, PRESSED and LONG_HELD, with a 24-bit counter cnt.
REQ-015 In IDLE, a press event SHALL set press_pulse, move to PRESSED, clear cnt and increment press_count.
REQ-016 In PRESSED with no release: if cnt == LONG_CYCLES-1, the block SHALL set long_pulse, move to LONG_HELD and clear cnt; otherwise it SHALL increment cnt. long_pulse therefore occurs exactly LONG_CYCLES cycles after press_pulse.
REQ-017 In LONG_HELD with no release: if cnt == REPEAT_CYCLES-1, the block SHALL set repeat_pulse and clear cnt; otherwise it SHALL increment cnt.
REQ-018 A release event in PRESSED or LONG_HELD SHALL set release_pulse, move to IDLE and clear cnt.
REQ-019 A release takes priority over a threshold reached on the same edge: no long_pulse or repeat_pulse is issued on that edge.
REQ-020 press_count SHALL wrap from 255 to 0 with no other effect.
REQ-021 held SHALL be 1 in PRESSED and LONG_HELD and 0 in IDLE.

Reset
REQ-022 While reset=0, the block SHALL asynchronously force state=IDLE, cnt=0, btn_q=0, press_count=0 and all strobes and held to 0.
REQ-023 Reset asserted mid-hold SHALL abort the hold with no release_pulse.
REQ-024 If button_clean=1 at reset deassertion, a press_pulse SHALL occur at the first clock edge after deassertion.

Configuration
REQ-025 With macro AUTO_REPEAT_EN defined, the block SHALL implement REQ-017.
REQ-026 With AUTO_REPEAT_EN undefined, repeat_pulse SHALL be tied to 0 and cnt SHALL hold at 0 in LONG_HELD; all other behaviour is unchanged.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-027 Reset=0 with button_clean toggling -> all outputs stay 0 and press_count=0.
REQ-028 button_clean high 3 cycles, then low -> press_pulse at edge k, release_pulse at edge k+3, no long_pulse, press_count=1, held high for cycles k..k+2.
REQ-029 AUTO_REPEAT_EN defined, button_clean high 22 cycles -> press at k, long at k+8, repeat at k+12, k+16 and k+20, release at k+22.
REQ-030 AUTO_REPEAT_EN undefined, same stimulus as REQ-029 -> long at k+8, no repeat_pulse ever, release at k+22.
REQ-031 button_clean sampled 0 first at edge k+8 -> release_pulse at k+8, no long_pulse; a separate hold to k+12 then release -> release_pulse at k+12, no repeat_pulse.
REQ-032 256 short presses -> press_count reads 0; reset asserted during LONG_HELD -> outputs 0 immediately without a clock, and no release_pulse.
